// File: rtl/ssp_uart_pkg.sv
// Shared widths, frame geometry and FSM state type for the SSP_UART command master.
package ssp_uart_pkg;

    localparam int unsigned SSP_RA_W       = 3;
    localparam int unsigned SSP_DATA_W     = 12;
    localparam int unsigned SSP_FRAME_BITS = 16;
    localparam int unsigned SSP_HDR_BITS   = 4;
    localparam int unsigned SSP_BIT_W      = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } ssp_mst_state_e;

    // Width of a down-counter able to hold the largest phase length minus one.
    function automatic int unsigned div_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/ssp_sck_gen.sv
// SCK half-period divider and frame bit counter (bit 15 down to 0).
module ssp_sck_gen
    import ssp_uart_pkg::*;
#(
    parameter int unsigned SCK_HALF = 2,
    parameter int unsigned DIV_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 sck,
    output logic                 rise_stb,
    output logic                 fall_stb,
    output logic [SSP_BIT_W-1:0] bit_idx,
    output logic                 done
);

    localparam logic [DIV_W-1:0]     HALF_RELOAD = DIV_W'(SCK_HALF - 1);
    localparam logic [SSP_BIT_W-1:0] FIRST_BIT   = SSP_BIT_W'(SSP_FRAME_BITS - 1);

    logic                 run_q, run_d;
    logic                 hi_q, hi_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [SSP_BIT_W-1:0] bit_q, bit_d;
    logic                 half_end_c;

    // Half-period countdown; a period ends after its high half, then the bit index steps down.
    always_comb begin
        run_d      = run_q;
        hi_d       = hi_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        half_end_c = run_q && (cnt_q == '0);
        rise_stb   = half_end_c && !hi_q;
        fall_stb   = half_end_c && hi_q;
        done       = fall_stb && (bit_q == '0);
        if (start) begin
            run_d = 1'b1;
            hi_d  = 1'b0;
            cnt_d = HALF_RELOAD;
            bit_d = FIRST_BIT;
        end else if (run_q) begin
            if (!half_end_c) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                cnt_d = HALF_RELOAD;
                hi_d  = !hi_q;
                if (hi_q) begin
                    if (bit_q == '0) begin
                        run_d = 1'b0;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
            end
        end
    end

    // Divider and bit counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            hi_q  <= 1'b0;
            cnt_q <= '0;
            bit_q <= '0;
        end else begin
            run_q <= run_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

    assign sck     = hi_q;
    assign bit_idx = bit_q;

endmodule

// File: rtl/ssp_uart_cmd_master.sv
// SSP frame engine: one register request in, one 16-bit SSP frame out, read data captured back.
module ssp_uart_cmd_master
    import ssp_uart_pkg::*;
#(
    parameter int unsigned SCK_HALF  = 2,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned GAP_CYC   = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SSP_RA_W-1:0]   req_ra,
    input  logic                  req_wnr,
    input  logic [SSP_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_wnr,
    output logic [SSP_DATA_W-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  SSP_SSEL,
    output logic                  SSP_SCK,
    output logic [SSP_RA_W-1:0]   SSP_RA,
    output logic                  SSP_WnR,
    output logic                  SSP_En,
    output logic                  SSP_EOC,
    output logic [SSP_DATA_W-1:0] SSP_DI,
    input  logic [SSP_DATA_W-1:0] SSP_DO
);

    localparam int unsigned          DIV_W        = div_width(SCK_HALF, SETUP_CYC, GAP_CYC);
    localparam logic [DIV_W-1:0]     SETUP_RELOAD = DIV_W'(SETUP_CYC - 1);
    localparam logic [DIV_W-1:0]     HOLD_RELOAD  = DIV_W'(SCK_HALF - 1);
    localparam logic [DIV_W-1:0]     GAP_RELOAD   = DIV_W'(GAP_CYC - 1);
    localparam logic [SSP_BIT_W-1:0] EN_FIRST_BIT = SSP_BIT_W'(SSP_FRAME_BITS - SSP_HDR_BITS - 1);

    ssp_mst_state_e        state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  ssel_q, ssel_d;
    logic [SSP_RA_W-1:0]   ra_q, ra_d;
    logic                  wnr_q, wnr_d;
    logic [SSP_DATA_W-1:0] di_q, di_d;
    logic                  en_q, en_d;
    logic                  eoc_q, eoc_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_wnr_q, rsp_wnr_d;
    logic [SSP_DATA_W-1:0] rdata_q, rdata_d;

    logic                  start_c;
    logic                  sck;
    logic                  rise_stb;
    logic                  fall_stb;
    logic                  done;
    logic [SSP_BIT_W-1:0]  bit_idx;
    logic [SSP_BIT_W-1:0]  next_bit_c;

    ssp_sck_gen #(
        .SCK_HALF (SCK_HALF),
        .DIV_W    (DIV_W)
    ) u_sck_gen (
        .clk      (Clk),
        .rst      (Rst),
        .start    (start_c),
        .sck      (sck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .bit_idx  (bit_idx),
        .done     (done)
    );

    // Frame sequencing; En/EOC are set up for the coming period at each period boundary.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ssel_d      = ssel_q;
        ra_d        = ra_q;
        wnr_d       = wnr_q;
        di_d        = di_q;
        en_d        = en_q;
        eoc_d       = eoc_q;
        rsp_valid_d = 1'b0;
        rsp_wnr_d   = rsp_wnr_q;
        rdata_d     = rdata_q;
        start_c     = 1'b0;
        next_bit_c  = bit_idx - 1'b1;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_RELOAD;
                    ra_d    = req_ra;
                    wnr_d   = req_wnr;
                    di_d    = req_wdata;
                    ssel_d  = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    start_c = 1'b1;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (rise_stb && (bit_idx == '0)) begin
                    rdata_d = SSP_DO;
                end
                if (done) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_RELOAD;
                    en_d    = 1'b0;
                    eoc_d   = 1'b0;
                end else if (fall_stb) begin
                    en_d  = (next_bit_c <= EN_FIRST_BIT);
                    eoc_d = (next_bit_c == '0);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d     = GAP;
                    cnt_d       = GAP_RELOAD;
                    ssel_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_wnr_d   = wnr_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset clears everything including the ready flag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            ssel_q      <= 1'b0;
            ra_q        <= '0;
            wnr_q       <= 1'b0;
            di_q        <= '0;
            en_q        <= 1'b0;
            eoc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wnr_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            ssel_q      <= ssel_d;
            ra_q        <= ra_d;
            wnr_q       <= wnr_d;
            di_q        <= di_d;
            en_q        <= en_d;
            eoc_q       <= eoc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wnr_q   <= rsp_wnr_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wnr   = rsp_wnr_q;
    assign rsp_rdata = rdata_q;
    assign SSP_SSEL  = ssel_q;
    assign SSP_SCK   = sck;
    assign SSP_RA    = ra_q;
    assign SSP_WnR   = wnr_q;
    assign SSP_En    = en_q;
    assign SSP_EOC   = eoc_q;
    assign SSP_DI    = di_q;

endmodule

// File: tb/tb_ssp_uart_cmd_master.sv
// Bench for ssp_uart_cmd_master: frame-offset reference model plus directed scenarios.
module tb_ssp_uart_cmd_master;

    localparam int H  = 2;
    localparam int S  = 2;
    localparam int G  = 2;
    localparam int L  = S + 33 * H;   // SSEL-high length
    localparam int KR = S + 31 * H;   // edge offset of SCK rise in the last period

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;

    logic        req_valid = 1'b0;
    logic [2:0]  req_ra    = '0;
    logic        req_wnr   = 1'b0;
    logic [11:0] req_wdata = '0;
    logic [11:0] SSP_DO    = '0;
    logic        req_ready, rsp_valid, rsp_wnr, busy;
    logic [11:0] rsp_rdata, SSP_DI;
    logic        SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC;
    logic [2:0]  SSP_RA;

    logic        r1_valid = 1'b0;
    logic [11:0] r1_do    = '0;
    logic        r1_ready, r1_rsp_valid, r1_rsp_wnr, r1_busy;
    logic [11:0] r1_rdata, r1_di;
    logic        r1_ssel, r1_sck, r1_wnr, r1_en, r1_eoc;
    logic [2:0]  r1_ra;

    ssp_uart_cmd_master #(.SCK_HALF(H), .SETUP_CYC(S), .GAP_CYC(G)) u_dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_ra(req_ra), .req_wnr(req_wnr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_wnr(rsp_wnr), .rsp_rdata(rsp_rdata), .busy(busy),
        .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR),
        .SSP_En(SSP_En), .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO)
    );

    ssp_uart_cmd_master #(.SCK_HALF(1), .SETUP_CYC(1), .GAP_CYC(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst), .req_valid(r1_valid), .req_ready(r1_ready),
        .req_ra(3'd1), .req_wnr(1'b1), .req_wdata(12'h0F0),
        .rsp_valid(r1_rsp_valid), .rsp_wnr(r1_rsp_wnr), .rsp_rdata(r1_rdata), .busy(r1_busy),
        .SSP_SSEL(r1_ssel), .SSP_SCK(r1_sck), .SSP_RA(r1_ra), .SSP_WnR(r1_wnr),
        .SSP_En(r1_en), .SSP_EOC(r1_eoc), .SSP_DI(r1_di), .SSP_DO(r1_do)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic        acc_pending = 1'b0;
    logic        have_frame  = 1'b0;
    logic        seen_clean  = 1'b0;
    int          acc_cyc     = 0;
    logic [2:0]  m_ra        = '0;
    logic        m_wnr       = 1'b0;
    logic [11:0] m_di        = '0;
    logic [11:0] m_rdata     = '0;
    logic        m_rsp_wnr   = 1'b0;
    logic [11:0] do_target   = 12'h000;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            have_frame = 1'b0;
            seen_clean = 1'b0;
            m_ra       = '0;
            m_wnr      = 1'b0;
            m_di       = '0;
            m_rdata    = '0;
            m_rsp_wnr  = 1'b0;
        end else begin
            cyc++;
            seen_clean = 1'b1;
            if (acc_pending) begin
                have_frame = 1'b1;
                acc_cyc    = cyc;
                m_ra       = req_ra;
                m_wnr      = req_wnr;
                m_di       = req_wdata;
            end
            if (have_frame && (cyc - acc_cyc) == KR) m_rdata = SSP_DO;
            if (have_frame && (cyc - acc_cyc) == L)  m_rsp_wnr = m_wnr;
        end
    end

    // SSP_DO carries the target value while EOC is up, noise otherwise.
    always @(posedge Clk) begin
        #2;
        SSP_DO = SSP_EOC ? do_target : 12'($urandom);
    end

    // Compare process: every output every cycle against the frame-offset model.
    int   k, j, b;
    logic e_ssel, e_sck, e_en, e_eoc, e_rsp, e_busy, e_ready, in_sh;
    always @(negedge Clk) begin
        k       = have_frame ? (cyc - acc_cyc) : 1000000;
        j       = k - S;
        in_sh   = (j >= 0) && (j < 32 * H);
        b       = in_sh ? (15 - j / (2 * H)) : 99;
        e_ssel  = (k < L);
        e_sck   = in_sh && ((j % (2 * H)) >= H);
        e_en    = in_sh && (b <= 11);
        e_eoc   = in_sh && (b == 0);
        e_rsp   = (k == L);
        e_busy  = (k < L + G);
        e_ready = seen_clean && !e_busy;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy",      32'(busy),      32'(e_busy));
        chk("ssel",      32'(SSP_SSEL),  32'(e_ssel));
        chk("sck",       32'(SSP_SCK),   32'(e_sck));
        chk("en",        32'(SSP_En),    32'(e_en));
        chk("eoc",       32'(SSP_EOC),   32'(e_eoc));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("ra",        32'(SSP_RA),    32'(m_ra));
        chk("wnr",       32'(SSP_WnR),   32'(m_wnr));
        chk("di",        32'(SSP_DI),    32'(m_di));
        chk("rsp_wnr",   32'(rsp_wnr),   32'(m_rsp_wnr));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        acc_pending = req_valid && req_ready;
    end

    // ---------------- waveform statistics ----------------
    int cur_hi = 0, cur_rise = 0, cur_en = 0, cur_eoc = 0, cur_lo = 0;
    int last_hi = 0, last_rise = 0, last_en = 0, last_eoc = 0, last_lo = 0;
    int rsp_cnt = 0, acc_cnt = 0, acc_t_prev = 0, acc_t_last = 0;
    logic [11:0] rsp_rdata_at = '0;
    logic        rsp_wnr_at   = 1'b0;
    logic        ssel_prev = 1'b0, sck_prev = 1'b0;

    always @(negedge Clk) begin
        if (SSP_SSEL) begin
            if (!ssel_prev) begin
                last_lo = cur_lo; cur_hi = 0; cur_rise = 0; cur_en = 0; cur_eoc = 0;
            end
            cur_hi++;
            if (SSP_SCK && !sck_prev) cur_rise++;
            if (SSP_En) cur_en++;
            if (SSP_EOC) cur_eoc++;
        end else begin
            if (ssel_prev) begin
                last_hi = cur_hi; last_rise = cur_rise; last_en = cur_en; last_eoc = cur_eoc;
                cur_lo = 0;
            end
            cur_lo++;
        end
        if (rsp_valid) begin
            rsp_cnt++; rsp_rdata_at = rsp_rdata; rsp_wnr_at = rsp_wnr;
        end
        if (req_valid && req_ready) begin
            acc_cnt++; acc_t_prev = acc_t_last; acc_t_last = cyc + 1;
        end
        ssel_prev = SSP_SSEL;
        sck_prev  = SSP_SCK;
    end

    int   hi1 = 0, rise1 = 0, sckhi1 = 0, rsp1_cnt = 0;
    logic ssel1_prev = 1'b0, sck1_prev = 1'b0;
    always @(negedge Clk) begin
        if (r1_ssel) begin
            hi1++;
            if (r1_sck) sckhi1++;
            if (r1_sck && !sck1_prev) rise1++;
        end
        if (r1_rsp_valid) rsp1_cnt++;
        ssel1_prev = r1_ssel;
        sck1_prev  = r1_sck;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] ra, input logic wnr, input logic [11:0] wd);
        int n;
        @(posedge Clk); #2;
        req_ra = ra; req_wnr = wnr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (n < 300) begin
            @(negedge Clk);
            if (req_ready) break;
            n++;
        end
        chk("accept_in_time", 32'(n < 300), 32'd1);
        @(posedge Clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 300) begin
            @(negedge Clk); #1;
            n++;
        end
        chk("b2b_accept_in_time", 32'(acc_cnt >= target), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int rsp_before, n;
        repeat (3) @(posedge Clk);
        #1 chk("ready_in_reset", 32'(req_ready), 32'd0);
        #1 Rst = 1'b0;
        @(posedge Clk); #1;
        chk("ready_after_release", 32'(req_ready), 32'd1);

        // Write RA=3 data A5C
        send(3'd3, 1'b1, 12'hA5C);
        repeat (75) @(posedge Clk); #1;
        chk("wr_ssel_len",  32'(last_hi),    32'd68);
        chk("wr_sck_rises", 32'(last_rise),  32'd16);
        chk("wr_en_cycles", 32'(last_en),    32'd48);
        chk("wr_eoc_cyc",   32'(last_eoc),   32'd4);
        chk("wr_rsp_count", 32'(rsp_cnt),    32'd1);
        chk("wr_rsp_wnr",   32'(rsp_wnr_at), 32'd1);
        chk("wr_di_held",   32'(SSP_DI),     32'h0A5C);

        // Read RA=5, final-period SSP_DO = 3C1
        do_target = 12'h3C1;
        send(3'd5, 1'b0, 12'h000);
        repeat (75) @(posedge Clk); #1;
        chk("rd_rsp_count", 32'(rsp_cnt),      32'd2);
        chk("rd_rdata",     32'(rsp_rdata_at), 32'h03C1);
        chk("rd_rsp_wnr",   32'(rsp_wnr_at),   32'd0);
        do_target = 12'h000;
        repeat (20) @(posedge Clk); #1;
        chk("rd_rdata_held", 32'(rsp_rdata), 32'h03C1);

        // Back-to-back with valid held
        n = acc_cnt;
        @(posedge Clk); #2;
        req_ra = 3'd1; req_wnr = 1'b1; req_wdata = 12'h123; req_valid = 1'b1;
        wait_acc(n + 1);
        @(posedge Clk); #2;
        req_ra = 3'd6; req_wnr = 1'b0; req_wdata = 12'h456;
        wait_acc(n + 2);
        @(posedge Clk); #2;
        req_valid = 1'b0;
        chk("b2b_spacing", 32'(acc_t_last - acc_t_prev), 32'd71);
        chk("b2b_gap_min", 32'(last_lo >= 2), 32'd1);
        repeat (75) @(posedge Clk); #1;
        chk("b2b_rsp_count", 32'(rsp_cnt), 32'd4);

        // Reset in period b=7
        send(3'd2, 1'b0, 12'h000);
        rsp_before = rsp_cnt;
        repeat (35) @(posedge Clk);
        #1 Rst = 1'b1;
        #1;
        chk("rst_ssel",  32'(SSP_SSEL),  32'd0);
        chk("rst_sck",   32'(SSP_SCK),   32'd0);
        chk("rst_en",    32'(SSP_En),    32'd0);
        chk("rst_eoc",   32'(SSP_EOC),   32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ra",    32'(SSP_RA),    32'd0);
        chk("rst_di",    32'(SSP_DI),    32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        repeat (2) @(posedge Clk);
        #2 Rst = 1'b0;
        @(posedge Clk); #1;
        chk("rst_ready_next", 32'(req_ready), 32'd1);
        repeat (40) @(posedge Clk); #1;
        chk("rst_no_rsp", 32'(rsp_cnt), 32'(rsp_before));
        send(3'd6, 1'b1, 12'h5A3);
        repeat (75) @(posedge Clk); #1;
        chk("post_rst_ssel_len", 32'(last_hi),    32'd68);
        chk("post_rst_rsp",      32'(rsp_cnt),    32'(rsp_before + 1));
        chk("post_rst_rsp_wnr",  32'(rsp_wnr_at), 32'd1);

        // Minimum-parameter instance
        @(posedge Clk); #2;
        r1_valid = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge Clk);
            if (r1_ready) break;
            n++;
        end
        chk("p1_accept_in_time", 32'(n < 100), 32'd1);
        @(posedge Clk); #2;
        r1_valid = 1'b0;
        repeat (45) @(posedge Clk); #1;
        chk("p1_ssel_len",  32'(hi1),      32'd34);
        chk("p1_sck_rises", 32'(rise1),    32'd16);
        chk("p1_sck_high",  32'(sckhi1),   32'd16);
        chk("p1_rsp",       32'(rsp1_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
